// File: rtl/ws2812_tx.sv
// ws2812_tx: eight-lane WS2812 serializer. Streams 64 pixels of 24-bit colour per frame
// from the layer RAMs with one-pixel read-ahead, then holds the lines low for the latch interval.
module ws2812_tx #(
    parameter int unsigned BIT_CNT = 50,
    parameter int unsigned T0H_CNT = 16,
    parameter int unsigned T1H_CNT = 32,
    parameter int unsigned RST_CNT = 12000
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         data_rdy_in,
    input  logic [191:0] ram_data_in,
    output logic         ram_rd_en_out,
    output logic [5:0]   ram_rd_addr_out,
    output logic [7:0]   bit_out,
    output logic         busy_out,
    output logic         done_out
);

    localparam int unsigned LANES    = 8;
    localparam int unsigned PIX_BITS = 24;
    localparam int unsigned CW       = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam int unsigned LW       = (RST_CNT > 1) ? $clog2(RST_CNT) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CNT);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CNT);
    localparam logic [LW-1:0] LAT_LAST = LW'(RST_CNT - 1);
    localparam logic [4:0]    TOP_BIT  = 5'(PIX_BITS - 1);
    localparam logic [5:0]    LAST_PIX = 6'd63;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        SEND  = 3'd3,
        LATCH = 3'd4
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]                    cnt, cnt_n;
    logic [4:0]                       bidx, bidx_n;
    logic [5:0]                       pix, pix_n;
    logic [LW-1:0]                    lat, lat_n;
    logic [LANES-1:0][PIX_BITS-1:0]   sh, sh_n;
    logic [191:0]                     hold, hold_n;
    logic                             cap, cap_n;
    logic                             pending, pending_n;

    logic                             rd_en_n;
    logic [5:0]                       rd_addr_n;
    logic [7:0]                       bit_n;
    logic                             busy_n;
    logic                             done_n;

    // Next-state, datapath and next-output computation; outputs are registered below.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bidx_n    = bidx;
        pix_n     = pix;
        lat_n     = lat;
        sh_n      = sh;
        pending_n = pending;
        done_n    = 1'b0;
        cap_n     = ram_rd_en_out;
        hold_n    = cap ? ram_data_in : hold;

        if (state != IDLE && data_rdy_in) begin
            pending_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (data_rdy_in || pending) begin
                    state_n   = LOAD;
                    pending_n = 1'b0;
                    pix_n     = '0;
                end
            end
            LOAD: begin
                state_n = FETCH;
                pix_n   = '0;
            end
            FETCH: begin
                state_n = SEND;
                sh_n    = ram_data_in;
                cnt_n   = '0;
                bidx_n  = TOP_BIT;
                pix_n   = '0;
            end
            SEND: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (bidx == 5'd0) begin
                        if (pix == LAST_PIX) begin
                            state_n = LATCH;
                            lat_n   = '0;
                        end else begin
                            // Pixel boundary: the prefetched word takes over with no gap.
                            pix_n  = pix + 6'd1;
                            bidx_n = TOP_BIT;
                            sh_n   = hold;
                        end
                    end else begin
                        bidx_n = bidx - 5'd1;
                        for (int unsigned k = 0; k < LANES; k++) begin
                            sh_n[k] = {sh[k][PIX_BITS-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            LATCH: begin
                if (lat == LAT_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    lat_n = lat + LW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Prefetch the next pixel on the first clock of each pixel except the last one.
        rd_en_n = (state_n == LOAD) ||
                  (state_n == SEND && cnt_n == '0 && bidx_n == TOP_BIT && pix_n != LAST_PIX);

        if (state_n == LOAD) begin
            rd_addr_n = '0;
        end else if (rd_en_n) begin
            rd_addr_n = pix_n + 6'd1;
        end else begin
            rd_addr_n = ram_rd_addr_out;
        end

        for (int unsigned k = 0; k < LANES; k++) begin
            bit_n[k] = (state_n == SEND) &&
                       (cnt_n < (sh_n[k][PIX_BITS-1] ? T1H_C : T0H_C));
        end

        busy_n = (state_n != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            cnt             <= '0;
            bidx            <= '0;
            pix             <= '0;
            lat             <= '0;
            sh              <= '0;
            hold            <= '0;
            cap             <= 1'b0;
            pending         <= 1'b0;
            ram_rd_en_out   <= 1'b0;
            ram_rd_addr_out <= '0;
            bit_out         <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bidx            <= bidx_n;
            pix             <= pix_n;
            lat             <= lat_n;
            sh              <= sh_n;
            hold            <= hold_n;
            cap             <= cap_n;
            pending         <= pending_n;
            ram_rd_en_out   <= rd_en_n;
            ram_rd_addr_out <= rd_addr_n;
            bit_out         <= bit_n;
            busy_out        <= busy_n;
            done_out        <= done_n;
        end
    end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: scoreboard bench for ws2812_tx with a registered 8-layer RAM model
// and reduced timing parameters so several whole frames fit in a short run.
module tb_ws2812_tx;

    localparam int BIT_CNT   = 6;
    localparam int T0H_CNT   = 2;
    localparam int T1H_CNT   = 4;
    localparam int RST_CNT   = 24;
    localparam int NPIX      = 64;
    localparam int NBITS     = NPIX * 24;
    localparam int FRAME_LEN = 2 + NBITS * BIT_CNT + RST_CNT;

    logic         clk = 1'b0;
    logic         rst_in;
    logic         data_rdy_in;
    logic [191:0] ram_data_in;
    logic         ram_rd_en_out;
    logic [5:0]   ram_rd_addr_out;
    logic [7:0]   bit_out;
    logic         busy_out;
    logic         done_out;

    logic [191:0] mem [NPIX];
    logic [7:0]   exp_q [$];
    int           tests_run    = 0;
    int           tests_failed = 0;

    ws2812_tx #(
        .BIT_CNT(BIT_CNT),
        .T0H_CNT(T0H_CNT),
        .T1H_CNT(T1H_CNT),
        .RST_CNT(RST_CNT)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .data_rdy_in    (data_rdy_in),
        .ram_data_in    (ram_data_in),
        .ram_rd_en_out  (ram_rd_en_out),
        .ram_rd_addr_out(ram_rd_addr_out),
        .bit_out        (bit_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk = ~clk;

    // Layer RAMs: read data appears one clock after the strobe.
    always @(posedge clk) begin
        if (ram_rd_en_out) ram_data_in <= mem[ram_rd_addr_out];
    end

    // Expected lane vectors, pixel 0 first, MSB first.
    task automatic push_frame();
        for (int n = 0; n < NPIX; n++) begin
            for (int b = 23; b >= 0; b--) begin
                logic [7:0] v;
                for (int k = 0; k < 8; k++) v[k] = mem[n][24*k+b];
                exp_q.push_back(v);
            end
        end
    endtask

    // Follows one frame from the clock before its LOAD edge to its done_out clock.
    task automatic run_frame(input string tag, input int p0, input int p1, input int p2,
                             input bit pulse_at_done);
        int cyc = 0, busy_cnt = 0, bitn = 0, off = 0, rds = 0, done_cyc = 0, nprint = 0;
        bit bad = 0, addr_bad = 0, latch_bad = 0, pushed = 0, prev_busy = 0;
        bit start_bad = 0, done_ok = 0;
        logic [7:0] exp_v = '0, wave, got_first = '0, want_first = '0;
        int bad_off = 0;
        while (done_cyc == 0 && cyc < FRAME_LEN + 100) begin
            @(negedge clk);
            cyc++;
            if (busy_out === 1'b1) busy_cnt++;
            if (cyc == 1 && !(busy_out === 1'b1 && ram_rd_en_out === 1'b1 &&
                              ram_rd_addr_out === 6'd0 && bit_out === 8'h00 && done_out === 1'b0))
                start_bad = 1;
            if (cyc == 2 && !(busy_out === 1'b1 && ram_rd_en_out === 1'b0 && bit_out === 8'h00))
                start_bad = 1;
            if (ram_rd_en_out === 1'b1) begin
                if (ram_rd_addr_out !== 6'(rds)) addr_bad = 1;
                rds++;
            end
            if (cyc >= 3 && bitn < NBITS) begin
                if (off == 0) begin
                    bad = 0;
                    if (exp_q.size() == 0) begin
                        exp_v = 8'hxx;
                        bad   = 1;
                    end else begin
                        exp_v = exp_q.pop_front();
                    end
                end
                for (int k = 0; k < 8; k++) wave[k] = (off < (exp_v[k] ? T1H_CNT : T0H_CNT));
                if (bit_out !== wave && !bad) begin
                    bad = 1;
                    got_first = bit_out;
                    want_first = wave;
                    bad_off = off;
                end
                off++;
                if (off == BIT_CNT) begin
                    tests_run++;
                    if (bad) begin
                        tests_failed++;
                        if (nprint < 8)
                            $display("FAIL %s_bit%0d off %0d: bit_out=%b expected %b",
                                     tag, bitn, bad_off, got_first, want_first);
                        nprint++;
                    end
                    off = 0;
                    bitn++;
                end
            end else if (bitn >= NBITS && bit_out !== 8'h00) begin
                latch_bad = 1;
            end
            if (done_out === 1'b1) begin
                done_cyc = cyc;
                done_ok  = prev_busy && (busy_out === 1'b0);
            end
            prev_busy = (busy_out === 1'b1);
            data_rdy_in = (cyc == p0 || cyc == p1 || cyc == p2) ||
                          (pulse_at_done && done_cyc != 0);
            if (data_rdy_in && !pushed) begin
                push_frame();
                pushed = 1;
            end
        end

        tests_run++;
        if (start_bad) begin
            tests_failed++;
            $display("FAIL %s_start: LOAD/FETCH entry wrong, expected rd strobe addr 0 then idle lines", tag);
        end
        tests_run++;
        if (done_cyc != FRAME_LEN + 1 || !done_ok) begin
            tests_failed++;
            $display("FAIL %s_done: done_out at cycle %0d (busy edge ok=%0d) expected cycle %0d",
                     tag, done_cyc, done_ok, FRAME_LEN + 1);
        end
        tests_run++;
        if (busy_cnt != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL %s_busy_len: busy high %0d clocks expected %0d", tag, busy_cnt, FRAME_LEN);
        end
        tests_run++;
        if (rds != NPIX || addr_bad) begin
            tests_failed++;
            $display("FAIL %s_reads: %0d strobes (addr order bad=%0d) expected 64 in order 0..63",
                     tag, rds, addr_bad);
        end
        tests_run++;
        if (latch_bad || bitn != NBITS) begin
            tests_failed++;
            $display("FAIL %s_latch: %0d bits seen, latch high=%0d expected %0d bits and low latch",
                     tag, bitn, latch_bad, NBITS);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        data_rdy_in = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bit_out, busy_out, done_out, ram_rd_en_out, ram_rd_addr_out} !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: bit=%h busy=%b done=%b rd=%b addr=%0d expected all 0",
                     bit_out, busy_out, done_out, ram_rd_en_out, ram_rd_addr_out);
        end
        rst_in = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy_out !== 1'b0 || ram_rd_en_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b rd=%b expected 0 0", busy_out, ram_rd_en_out);
        end
    endtask

    task automatic test_bit_timing();
        int hi0 [24];
        int hio [24];
        bit shape_bad = 0, pre_bad = 0;
        logic prev0 = 1'b0;
        for (int n = 0; n < NPIX; n++) mem[n] = '0;
        mem[0][23:0] = 24'h800000;
        for (int b = 0; b < 24; b++) begin
            hi0[b] = 0;
            hio[b] = 0;
        end
        @(negedge clk);
        data_rdy_in = 1'b1;
        for (int cyc = 1; cyc <= 2 + 24 * BIT_CNT; cyc++) begin
            @(negedge clk);
            data_rdy_in = 1'b0;
            if (cyc <= 2) begin
                if (bit_out !== 8'h00) pre_bad = 1;
            end else begin
                int b, o;
                b = (cyc - 3) / BIT_CNT;
                o = (cyc - 3) % BIT_CNT;
                if (bit_out[0] === 1'b1) hi0[b]++;
                if (bit_out[7:1] === 7'h7f) hio[b]++;
                if ((o == 0 && bit_out !== 8'hff) || (o > 0 && bit_out[0] === 1'b1 && prev0 !== 1'b1))
                    shape_bad = 1;
                prev0 = bit_out[0];
            end
        end
        tests_run++;
        if (pre_bad || shape_bad) begin
            tests_failed++;
            $display("FAIL bit_shape: pre-send high=%0d non-contiguous pulse=%0d expected 0 0",
                     pre_bad, shape_bad);
        end
        for (int b = 0; b < 24; b++) begin
            int want;
            want = (b == 0) ? T1H_CNT : T0H_CNT;
            tests_run++;
            if (hi0[b] != want || hio[b] != T0H_CNT) begin
                tests_failed++;
                $display("FAIL bit_timing_%0d: lane0 high %0d others high %0d expected %0d and %0d",
                         b, hi0[b], hio[b], want, T0H_CNT);
            end
        end
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_continuity();
        for (int n = 0; n < NPIX; n++)
            for (int k = 0; k < 8; k++) mem[n][24*k +: 24] = {3{8'(n)}};
        exp_q.delete();
        push_frame();
        data_rdy_in = 1'b1;
        run_frame("cont", 0, 0, 0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (done_out !== 1'b0 || busy_out !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL cont_after: done=%b busy=%b left=%0d expected 0 0 0",
                     done_out, busy_out, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit restarted = 0;
        for (int n = 0; n < NPIX; n++)
            for (int w = 0; w < 6; w++) mem[n][32*w +: 32] = $urandom;
        exp_q.delete();
        push_frame();
        data_rdy_in = 1'b1;
        run_frame("pend_a", 60, 700, 4000, 1'b0);
        run_frame("pend_b", 0, 0, 0, 1'b1);
        run_frame("pend_c", 0, 0, 0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_out !== 1'b0 || ram_rd_en_out !== 1'b0) restarted = 1;
        end
        tests_run++;
        if (restarted || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL pend_extra: extra frame started=%0d leftover=%0d expected 0 0",
                     restarted, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0, resumed = 0;
        for (int n = 0; n < NPIX; n++)
            for (int w = 0; w < 6; w++) mem[n][32*w +: 32] = $urandom;
        exp_q.delete();
        @(negedge clk);
        data_rdy_in = 1'b1;
        for (int i = 0; i < 40 * 24 * BIT_CNT && !found; i++) begin
            @(negedge clk);
            data_rdy_in = 1'b0;
            if (ram_rd_en_out === 1'b1 && ram_rd_addr_out === 6'd30) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL mid_reset_wait: read of pixel 30 not seen within bound");
        end
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        tests_run++;
        if ({bit_out, busy_out, done_out, ram_rd_en_out, ram_rd_addr_out} !== 17'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: bit=%h busy=%b done=%b rd=%b addr=%0d expected all 0",
                     bit_out, busy_out, done_out, ram_rd_en_out, ram_rd_addr_out);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_out !== 1'b0 || ram_rd_en_out !== 1'b0 || bit_out !== 8'h00) resumed = 1;
        end
        tests_run++;
        if (resumed) begin
            tests_failed++;
            $display("FAIL mid_reset_resume: activity after reset, expected idle");
        end
        push_frame();
        data_rdy_in = 1'b1;
        run_frame("restart", 0, 0, 0, 1'b0);
    endtask

    initial begin
        rst_in = 1'b1;
        data_rdy_in = 1'b0;
        for (int n = 0; n < NPIX; n++) mem[n] = '0;
        test_reset();
        test_bit_timing();
        test_continuity();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
